ccm_banked_mem: RTL and testbench

//  Parametrised multi-bank closely-coupled memory with two read ports (lo/hi) and one write port.
//  Low-order address interleaving across NUM_BANKS single-port banks.

---
 rtl/ccm_banked_mem_pkg.sv | 14 +
 rtl/ccm_bank_ram.sv | 32 +++
 rtl/ccm_banked_mem.sv | 241 ++++++++++++++++++++++++
 tb/tb_ccm_banked_mem.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccm_banked_mem_pkg.sv
// rtl/ccm_banked_mem_pkg.sv - shared defaults and types for the banked closely-coupled memory
package ccm_banked_mem_pkg;

  localparam int CCM_NUM_BANKS   = 4;
  localparam int CCM_DATA_WIDTH  = 39;
  localparam int CCM_ADDR_WIDTH  = 14;
  localparam int CCM_WB_MAX_WAIT = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    HI_PEND = 1'b1
  } ccm_rd_state_e;

endpackage

// File: rtl/ccm_bank_ram.sv
// rtl/ccm_bank_ram.sv - one single-port bank with a registered read port
module ccm_bank_ram #(
  parameter int DATA_WIDTH = 39,
  parameter int DEPTH      = 4096,
  parameter int ROW_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ROW_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // rdata only moves on a real read so a gated-on idle clock cannot disturb it
  always_ff @(posedge clk) begin
    if (ce && cs) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ccm_banked_mem.sv
// rtl/ccm_banked_mem.sv - interleaved multi-bank memory, two read lanes, posted write buffer
module ccm_banked_mem
  import ccm_banked_mem_pkg::*;
#(
  parameter int NUM_BANKS   = CCM_NUM_BANKS,
  parameter int DATA_WIDTH  = CCM_DATA_WIDTH,
  parameter int ADDR_WIDTH  = CCM_ADDR_WIDTH,
  parameter int WB_MAX_WAIT = CCM_WB_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_override,
  input  logic                  freeze,
  input  logic                  rd_valid_lo,
  input  logic [ADDR_WIDTH-1:0] rd_addr_lo,
  input  logic                  rd_valid_hi,
  input  logic [ADDR_WIDTH-1:0] rd_addr_hi,
  output logic                  rd_ready,
  output logic                  rd_dvalid_lo,
  output logic [DATA_WIDTH-1:0] rd_data_lo,
  output logic                  rd_dvalid_hi,
  output logic [DATA_WIDTH-1:0] rd_data_hi,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int ROW_W     = ADDR_WIDTH - BANK_BITS;
  localparam int CNT_W     = $clog2(WB_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(WB_MAX_WAIT);

  typedef logic [BANK_BITS-1:0]  bank_t;
  typedef logic [ROW_W-1:0]      row_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic  valid;
    bank_t bank;
    row_t  row;
    data_t data;
  } ccm_wbuf_t;

  ccm_rd_state_e    state_q, state_d;
  bank_t            hi_bank_q, hi_bank_d;
  row_t             hi_row_q, hi_row_d;
  ccm_wbuf_t        wbuf_q, wbuf_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  // Per-lane return pipeline, index 0 = lo, index 1 = hi
  logic [1:0] fire_q, fire_d, fwd_q, fwd_d, pend_q, pend_d, out_valid_q, out_valid_d;
  bank_t      src_bank_q [2], src_bank_d [2];
  data_t      fwd_data_q [2], fwd_data_d [2];
  data_t      pend_data_q [2], pend_data_d [2];
  data_t      out_data_q [2], out_data_d [2];

  bank_t lo_bank, hi_bank, wr_bank;
  row_t  lo_row, hi_row, wr_row;
  bank_t lane_bank [2];
  row_t  lane_row [2];
  logic [1:0] iss, dv;
  data_t raw [2], lane_data [2];
  logic  wb_urgent, conflict, drain, wr_acc, wr_direct;
  logic [NUM_BANKS-1:0] rd_use, bank_we, bank_cs, bank_ce;
  row_t  bank_addr [NUM_BANKS];
  data_t bank_wdata [NUM_BANKS], bank_rdata [NUM_BANKS];

  assign lo_bank = rd_addr_lo[BANK_BITS-1:0];
  assign lo_row  = rd_addr_lo[ADDR_WIDTH-1:BANK_BITS];
  assign hi_bank = rd_addr_hi[BANK_BITS-1:0];
  assign hi_row  = rd_addr_hi[ADDR_WIDTH-1:BANK_BITS];
  assign wr_bank = wr_addr[BANK_BITS-1:0];
  assign wr_row  = wr_addr[ADDR_WIDTH-1:BANK_BITS];

  always_comb begin
    state_d      = state_q;
    hi_bank_d    = hi_bank_q;
    hi_row_d     = hi_row_q;
    rd_ready     = 1'b0;
    iss          = '0;
    lane_bank[0] = lo_bank;
    lane_row[0]  = lo_row;
    lane_bank[1] = hi_bank;
    lane_row[1]  = hi_row;
    wb_urgent    = wbuf_q.valid && (wait_q == WAIT_SAT);
    conflict     = rd_valid_lo && rd_valid_hi && (lo_bank == hi_bank) && (lo_row != hi_row);

    case (state_q)
      IDLE: begin
        rd_ready = !freeze && !(wb_urgent &&
                   ((rd_valid_lo && lo_bank == wbuf_q.bank) || (rd_valid_hi && hi_bank == wbuf_q.bank)));
        if (rd_ready) begin
          iss = {rd_valid_hi && !conflict, rd_valid_lo};
          if (conflict) begin
            state_d   = HI_PEND;
            hi_bank_d = hi_bank;
            hi_row_d  = hi_row;
          end
        end
      end
      HI_PEND: begin
        lane_bank[1] = hi_bank_q;
        lane_row[1]  = hi_row_q;
        if (!(wb_urgent && wbuf_q.bank == hi_bank_q)) begin
          iss[1]  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_use = '0;
    for (int l = 0; l < 2; l++) begin
      if (iss[l]) rd_use[lane_bank[l]] = 1'b1;
    end

    // An urgent buffer already blocked every read to its bank, so this covers both drain cases
    drain     = wbuf_q.valid && !rd_use[wbuf_q.bank] && !rst;
    wr_ready  = !wbuf_q.valid || drain;
    wr_acc    = wr_valid && wr_ready;
    wr_direct = wr_acc && !rd_use[wr_bank] && !(drain && wbuf_q.bank == wr_bank) && !rst;

    wbuf_d = wbuf_q;
    if (drain) wbuf_d.valid = 1'b0;
    if (wr_acc && !wr_direct) begin
      wbuf_d.valid = 1'b1;
      wbuf_d.bank  = wr_bank;
      wbuf_d.row   = wr_row;
      wbuf_d.data  = wr_data;
    end

    if (!wbuf_q.valid || drain) wait_d = '0;
    else if (wait_q == WAIT_SAT) wait_d = wait_q;
    else wait_d = wait_q + 1'b1;

    bank_we = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_addr[b]  = '0;
      bank_wdata[b] = '0;
    end
    for (int l = 0; l < 2; l++) begin
      if (iss[l]) bank_addr[lane_bank[l]] = lane_row[l];
    end
    if (drain) begin
      bank_we[wbuf_q.bank]    = 1'b1;
      bank_addr[wbuf_q.bank]  = wbuf_q.row;
      bank_wdata[wbuf_q.bank] = wbuf_q.data;
    end
    if (wr_direct) begin
      bank_we[wr_bank]    = 1'b1;
      bank_addr[wr_bank]  = wr_row;
      bank_wdata[wr_bank] = wr_data;
    end
    bank_cs = rd_use | bank_we;
    bank_ce = bank_cs | {NUM_BANKS{clk_override}};

    for (int l = 0; l < 2; l++) begin
      fire_d[l]     = iss[l];
      src_bank_d[l] = lane_bank[l];
      fwd_d[l]      = iss[l] && wbuf_q.valid && (wbuf_q.bank == lane_bank[l]) && (wbuf_q.row == lane_row[l]);
      fwd_data_d[l] = wbuf_q.data;
    end
  end

  // Data arriving while frozen is parked in pend and shown once freeze drops
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      raw[l]       = fwd_q[l] ? fwd_data_q[l] : bank_rdata[src_bank_q[l]];
      dv[l]        = 1'b0;
      lane_data[l] = out_data_q[l];
      if (freeze) begin
        dv[l] = out_valid_q[l];
      end else if (fire_q[l]) begin
        dv[l]        = 1'b1;
        lane_data[l] = raw[l];
      end else if (pend_q[l]) begin
        dv[l]        = 1'b1;
        lane_data[l] = pend_data_q[l];
      end
      pend_d[l]      = freeze && (pend_q[l] || fire_q[l]);
      pend_data_d[l] = (freeze && fire_q[l]) ? raw[l] : pend_data_q[l];
      out_valid_d[l] = dv[l];
      out_data_d[l]  = lane_data[l];
    end
  end

  assign rd_dvalid_lo = dv[0];
  assign rd_data_lo   = lane_data[0];
  assign rd_dvalid_hi = dv[1];
  assign rd_data_hi   = lane_data[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_bank_q   <= '0;
      hi_row_q    <= '0;
      wbuf_q      <= '0;
      wait_q      <= '0;
      fire_q      <= '0;
      fwd_q       <= '0;
      pend_q      <= '0;
      out_valid_q <= '0;
      src_bank_q  <= '{default: '0};
      fwd_data_q  <= '{default: '0};
      pend_data_q <= '{default: '0};
      out_data_q  <= '{default: '0};
    end else begin
      state_q     <= state_d;
      hi_bank_q   <= hi_bank_d;
      hi_row_q    <= hi_row_d;
      wbuf_q      <= wbuf_d;
      wait_q      <= wait_d;
      fire_q      <= fire_d;
      fwd_q       <= fwd_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      src_bank_q  <= src_bank_d;
      fwd_data_q  <= fwd_data_d;
      pend_data_q <= pend_data_d;
      out_data_q  <= out_data_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ccm_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (2 ** ROW_W),
      .ROW_W      (ROW_W)
    ) u_ram (
      .clk   (clk),
      .ce    (bank_ce[b]),
      .cs    (bank_cs[b]),
      .we    (bank_we[b]),
      .addr  (bank_addr[b]),
      .wdata (bank_wdata[b]),
      .rdata (bank_rdata[b])
    );
  end

endmodule

// File: tb/tb_ccm_banked_mem.sv
// tb/tb_ccm_banked_mem.sv - directed self-checking bench for ccm_banked_mem
module tb_ccm_banked_mem;

  localparam int DW = 39;
  localparam int AW = 14;

  localparam logic [DW-1:0] DA = 39'h0A_1111_0010;
  localparam logic [DW-1:0] DB = 39'h0B_2222_0001;
  localparam logic [DW-1:0] DC = 39'h0C_3333_0004;
  localparam logic [DW-1:0] DD = 39'h0D_4444_0008;
  localparam logic [DW-1:0] DE = 39'h0E_5555_0005;
  localparam logic [DW-1:0] DF = 39'h0F_6666_0009;
  localparam logic [DW-1:0] DG = 39'h1A_7777_0004;
  localparam logic [DW-1:0] DH = 39'h1B_8888_000D;
  localparam logic [DW-1:0] DI = 39'h1C_9999_000D;

  logic          clk = 1'b0;
  logic          rst, clk_override, freeze;
  logic          rd_valid_lo, rd_valid_hi, rd_ready;
  logic [AW-1:0] rd_addr_lo, rd_addr_hi, wr_addr;
  logic          rd_dvalid_lo, rd_dvalid_hi, wr_valid, wr_ready;
  logic [DW-1:0] rd_data_lo, rd_data_hi, wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ccm_banked_mem #(
    .NUM_BANKS   (4),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .WB_MAX_WAIT (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_override (clk_override),
    .freeze       (freeze),
    .rd_valid_lo  (rd_valid_lo),
    .rd_addr_lo   (rd_addr_lo),
    .rd_valid_hi  (rd_valid_hi),
    .rd_addr_hi   (rd_addr_hi),
    .rd_ready     (rd_ready),
    .rd_dvalid_lo (rd_dvalid_lo),
    .rd_data_lo   (rd_data_lo),
    .rd_dvalid_hi (rd_dvalid_hi),
    .rd_data_hi   (rd_data_hi),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rd(input logic vl, input logic [AW-1:0] al, input logic vh, input logic [AW-1:0] ah);
    rd_valid_lo = vl;
    rd_addr_lo  = al;
    rd_valid_hi = vh;
    rd_addr_hi  = ah;
  endtask

  task automatic drive_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clk_override = 1'b0;
    freeze = 1'b0;
    drive_rd(1'b0, '0, 1'b0, '0);
    drive_wr(1'b0, '0, '0);
    tick();
    tick();
    check_eq("rst_dvalid_lo", rd_dvalid_lo, 0);
    check_eq("rst_dvalid_hi", rd_dvalid_hi, 0);
    check_eq("rst_data_lo", rd_data_lo, 0);
    check_eq("rst_data_hi", rd_data_hi, 0);
    check_eq("rst_rd_ready", rd_ready, 1);
    check_eq("rst_wr_ready", wr_ready, 1);
    freeze = 1'b1;
    #1;
    check_eq("rst_rd_ready_frozen", rd_ready, 0);
    freeze = 1'b0;
    rst = 1'b0;

    // Write then read back one cycle later
    drive_wr(1'b1, 14'h010, DA);
    #1;
    check_eq("t1_wr_ready", wr_ready, 1);
    tick();
    drive_wr(1'b0, '0, '0);
    drive_rd(1'b1, 14'h010, 1'b0, '0);
    #1;
    check_eq("t1_rd_ready", rd_ready, 1);
    tick();
    drive_rd(1'b0, '0, 1'b0, '0);
    check_eq("t1_dvalid_lo", rd_dvalid_lo, 1);
    check_eq("t1_data_lo", rd_data_lo, DA);
    check_eq("t1_dvalid_hi", rd_dvalid_hi, 0);
    tick();
    check_eq("t1_dvalid_pulse", rd_dvalid_lo, 0);

    drive_wr(1'b1, 14'h004, DC); tick();
    drive_wr(1'b1, 14'h008, DD); tick();
    drive_wr(1'b1, 14'h005, DE); tick();
    drive_wr(1'b1, 14'h00D, DI); tick();
    drive_wr(1'b0, '0, '0);

    // Same bank, different rows: lo now, hi one cycle later
    drive_rd(1'b1, 14'h004, 1'b1, 14'h008);
    #1;
    check_eq("t2_rd_ready_accept", rd_ready, 1);
    tick();
    check_eq("t2_dvalid_lo", rd_dvalid_lo, 1);
    check_eq("t2_data_lo", rd_data_lo, DC);
    check_eq("t2_dvalid_hi_early", rd_dvalid_hi, 0);
    #1;
    check_eq("t2_rd_ready_hipend", rd_ready, 0);
    drive_rd(1'b0, '0, 1'b0, '0);
    tick();
    check_eq("t2_dvalid_hi", rd_dvalid_hi, 1);
    check_eq("t2_data_hi", rd_data_hi, DD);
    check_eq("t2_dvalid_lo_off", rd_dvalid_lo, 0);

    // Identical addresses: no serialisation
    clk_override = 1'b1;
    drive_rd(1'b1, 14'h004, 1'b1, 14'h004);
    #1;
    check_eq("t3_rd_ready", rd_ready, 1);
    tick();
    check_eq("t3_dvalid_lo", rd_dvalid_lo, 1);
    check_eq("t3_dvalid_hi", rd_dvalid_hi, 1);
    check_eq("t3_data_lo", rd_data_lo, DC);
    check_eq("t3_data_hi", rd_data_hi, DC);
    #1;
    check_eq("t3_no_stall", rd_ready, 1);
    drive_rd(1'b0, '0, 1'b0, '0);
    clk_override = 1'b0;
    tick();

    // Write to 0x001 buffered behind a bank-1 read, then bank-1 reads every cycle
    drive_wr(1'b1, 14'h001, DB);
    drive_rd(1'b1, 14'h005, 1'b0, '0);
    #1;
    check_eq("t4_wr_ready_empty", wr_ready, 1);
    check_eq("t4_rd_ready", rd_ready, 1);
    tick();
    check_eq("t4_data_e", rd_data_lo, DE);
    drive_wr(1'b1, 14'h009, DF);
    drive_rd(1'b1, 14'h001, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("t4_rd_ready_w%0d", i), rd_ready, 1);
      check_eq($sformatf("t5_wr_ready_held_w%0d", i), wr_ready, 0);
      tick();
      check_eq($sformatf("t4_fwd_dvalid_w%0d", i), rd_dvalid_lo, 1);
      check_eq($sformatf("t4_fwd_data_w%0d", i), rd_data_lo, DB);
    end
    #1;
    check_eq("t4_drain_rd_ready", rd_ready, 0);
    check_eq("t5_drain_wr_ready", wr_ready, 1);
    tick();
    check_eq("t4_stall_no_dvalid", rd_dvalid_lo, 0);
    drive_wr(1'b0, '0, '0);
    #1;
    check_eq("t5_rd_ready_after", rd_ready, 1);
    check_eq("t5_wr_ready_buf_f", wr_ready, 0);
    tick();
    check_eq("t4_bank_dvalid", rd_dvalid_lo, 1);
    check_eq("t4_bank_data", rd_data_lo, DB);
    drive_rd(1'b0, '0, 1'b0, '0);
    #1;
    check_eq("t5_wr_ready_drain_f", wr_ready, 1);
    tick();
    drive_rd(1'b1, 14'h009, 1'b0, '0);
    tick();
    drive_rd(1'b0, '0, 1'b0, '0);
    check_eq("t5_data_f", rd_data_lo, DF);

    // A write in the same cycle as a read of the same address is not forwarded
    drive_wr(1'b1, 14'h004, DG);
    drive_rd(1'b1, 14'h004, 1'b0, '0);
    #1;
    check_eq("fw_wr_ready", wr_ready, 1);
    tick();
    drive_wr(1'b0, '0, '0);
    check_eq("fw_same_cycle_old", rd_data_lo, DC);
    tick();
    check_eq("fw_next_cycle_new", rd_data_lo, DG);
    drive_rd(1'b0, '0, 1'b0, '0);
    tick();

    // Freeze asserted in the HI_PEND cycle
    drive_rd(1'b1, 14'h004, 1'b1, 14'h008);
    #1;
    check_eq("t6_rd_ready_accept", rd_ready, 1);
    tick();
    drive_rd(1'b0, '0, 1'b0, '0);
    freeze = 1'b1;
    #1;
    check_eq("t6_frz_rd_ready", rd_ready, 0);
    check_eq("t6_frz_dvalid_lo", rd_dvalid_lo, 0);
    check_eq("t6_frz_dvalid_hi", rd_dvalid_hi, 0);
    tick();
    check_eq("t6_frz2_dvalid_lo", rd_dvalid_lo, 0);
    check_eq("t6_frz2_dvalid_hi", rd_dvalid_hi, 0);
    freeze = 1'b0;
    #1;
    check_eq("t6_thaw_dvalid_lo", rd_dvalid_lo, 1);
    check_eq("t6_thaw_data_lo", rd_data_lo, DG);
    check_eq("t6_thaw_dvalid_hi", rd_dvalid_hi, 1);
    check_eq("t6_thaw_data_hi", rd_data_hi, DD);
    tick();
    check_eq("t6_after_dvalid_lo", rd_dvalid_lo, 0);
    check_eq("t6_after_dvalid_hi", rd_dvalid_hi, 0);

    // Reset while a write sits in the buffer
    drive_wr(1'b1, 14'h00D, DH);
    drive_rd(1'b1, 14'h005, 1'b0, '0);
    #1;
    check_eq("rs_wr_ready", wr_ready, 1);
    tick();
    drive_wr(1'b0, '0, '0);
    drive_rd(1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("rs_wr_ready_after", wr_ready, 1);
    check_eq("rs_dvalid_lo", rd_dvalid_lo, 0);
    check_eq("rs_dvalid_hi", rd_dvalid_hi, 0);
    drive_rd(1'b1, 14'h00D, 1'b0, '0);
    tick();
    drive_rd(1'b0, '0, 1'b0, '0);
    check_eq("rs_dvalid_read", rd_dvalid_lo, 1);
    check_eq("rs_old_write_absent", rd_data_lo, DI);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
